hc4511_scan_driver: RTL and testbench

- Upstream feeder for the HC4511 BCD-to-7-segment latch/decoder in a time-multiplexed multi-digit display.
- Holds a DIGITS-wide packed BCD word and scans it one digit per slot.
- Per slot it drives the decoder's BCD input (A), latch enable (LE), blanking (BI_N) and lamp test (LT_N), plus a one-hot digit-common select.
- Provides anti-ghost blanking between slots, leading-zero suppression and tear-free frame-synchronous updates.

---
 rtl/hc4511_scan_driver_if.sv | 26 ++
 rtl/hc4511_scan_driver.sv | 174 +++++++++++++++++
 tb/tb_hc4511_scan_driver.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/hc4511_scan_driver_if.sv
// Bus between a value source (master) and the HC4511 scan driver (slave):
// packed BCD value and control in, decoder/digit-select drive out.
interface hc4511_scan_driver_if #(
   parameter int DIGITS = 4
);
   logic [4*DIGITS-1:0] bcd_in;
   logic                load;
   logic                lz_en;
   logic                test_n;
   logic [3:0]          A;
   logic                LE;
   logic                BI_N;
   logic                LT_N;
   logic [DIGITS-1:0]   dig_sel;
   logic                frame_done;

   modport master (
      output bcd_in, load, lz_en, test_n,
      input  A, LE, BI_N, LT_N, dig_sel, frame_done
   );

   modport slave (
      input  bcd_in, load, lz_en, test_n,
      output A, LE, BI_N, LT_N, dig_sel, frame_done
   );
endinterface

// File: rtl/hc4511_scan_driver.sv
// Time-multiplexed scan driver feeding an HC4511 BCD-to-7-segment
// latch/decoder. Each digit slot starts blanked with all commons off so the
// previous digit cannot ghost, presents the BCD digit while the latch is
// transparent, then latches it and enables that digit's common. The value
// on display only changes at a frame boundary, so a frame is never torn.
module hc4511_scan_driver #(
   parameter int DIGITS    = 4,
   parameter int SCAN_DIV  = 1000,
   parameter int BLANK_CYC = 4
) (
   input logic               clk,
   input logic               rst,
   hc4511_scan_driver_if.slave bus
);

   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
   localparam logic [SW-1:0] SETUP_CNT = SW'(BLANK_CYC);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

   typedef enum logic [1:0] {
      PH_BLANK,  // display blanked, commons off, latch transparent
      PH_SETUP,  // as BLANK; last cycle before the latch closes
      PH_HOLD    // latch closed, digit common on
   } phase_t;

   // Scan position
   logic [SW-1:0] slot_cnt, slot_nxt;
   logic [IW-1:0] idx, idx_nxt;
   logic          frame_end;
   phase_t        phase;

   // Data path
   logic [4*DIGITS-1:0] shadow;
   logic [4*DIGITS-1:0] work;
   logic                lz_q;
   logic [3:0]          digit;
   logic                digit_supp;
   logic                zero_run;

   // Next values of the registered outputs
   logic [3:0]        a_nxt;
   logic              le_nxt;
   logic              bi_n_nxt;
   logic [DIGITS-1:0] sel_nxt;
   logic              done_nxt;

   // Registered outputs
   logic [3:0]        a_q;
   logic              le_q;
   logic              bi_n_q;
   logic              lt_n_q;
   logic [DIGITS-1:0] sel_q;
   logic              done_q;

   // Scan position register: slot counter and digit index.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking (<=) so every register samples pre-edge values regardless of statement order.
      if (rst) begin
         slot_cnt <= '0;
         idx      <= '0;
      end else begin
         slot_cnt <= slot_nxt;
         idx      <= idx_nxt;
      end
   end

   // Next scan position: slot counter wraps and advances the digit index.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves a latch.
      slot_nxt  = slot_cnt + 1'b1;
      idx_nxt   = idx;
      frame_end = (slot_cnt == SLOT_LAST) && (idx == IDX_LAST);
      if (slot_cnt == SLOT_LAST) begin
         slot_nxt = '0;
         idx_nxt  = (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
   end

   // Phase decode of the current slot position.
   always_comb begin
      if (slot_cnt < SETUP_CNT) begin
         phase = PH_BLANK;
      end else if (slot_cnt == SETUP_CNT) begin
         phase = PH_SETUP;
      end else begin
         phase = PH_HOLD;
      end
   end

   // Select the current digit and find whether it is a leading zero.
   // Scanning from the top digit down, zero_run stays set while every digit
   // seen so far is zero; digit 0 is always shown.
   always_comb begin
      digit      = 4'd0;
      digit_supp = 1'b0;
      zero_run   = 1'b1;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         zero_run = zero_run & (work[4*k +: 4] == 4'd0);
         if (idx == IW'(k)) begin
            digit      = work[4*k +: 4];
            digit_supp = zero_run && (k != 0);
         end
      end
   end

   // Output decode for the phase; the registers below add one cycle.
   always_comb begin
      a_nxt    = digit;
      le_nxt   = 1'b0;
      bi_n_nxt = 1'b0;
      sel_nxt  = '0;
      done_nxt = frame_end;
      if (phase == PH_HOLD) begin
         le_nxt = 1'b1;
         for (int k = 0; k < DIGITS; k++) begin
            sel_nxt[k] = (idx == IW'(k));
         end
         // Lamp test uses test_n directly so BI_N is forced in the same
         // cycle that LT_N goes low.
         bi_n_nxt = !bus.test_n || !(lz_q && digit_supp);
      end
   end

   // Shadow/work value registers and the per-slot leading-zero enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow <= '0;
         work   <= '0;
         lz_q   <= 1'b0;
      end else begin
         if (bus.load) begin
            shadow <= bus.bcd_in;
         end
         // A load landing on the frame boundary bypasses the shadow so the
         // newest value is not lost for a whole frame.
         if (frame_end) begin
            work <= bus.load ? bus.bcd_in : shadow;
         end
         if (phase == PH_SETUP) begin
            lz_q <= bus.lz_en;
         end
      end
   end

   // Output registers; lamp test is a plain one-cycle delay of test_n.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= 4'd0;
         le_q   <= 1'b0;
         bi_n_q <= 1'b0;
         lt_n_q <= 1'b1;
         sel_q  <= '0;
         done_q <= 1'b0;
      end else begin
         a_q    <= a_nxt;
         le_q   <= le_nxt;
         bi_n_q <= bi_n_nxt;
         lt_n_q <= bus.test_n;
         sel_q  <= sel_nxt;
         done_q <= done_nxt;
      end
   end

   assign bus.A          = a_q;
   assign bus.LE         = le_q;
   assign bus.BI_N       = bi_n_q;
   assign bus.LT_N       = lt_n_q;
   assign bus.dig_sel    = sel_q;
   assign bus.frame_done = done_q;

endmodule

// File: tb/tb_hc4511_scan_driver.sv
// Self-checking bench for hc4511_scan_driver (DIGITS=4, SCAN_DIV=8,
// BLANK_CYC=2). Expected per-cycle outputs for each frame are pushed to a
// scoreboard queue and popped as the frame is observed.
module tb_hc4511_scan_driver;

   typedef struct packed {
      logic       fd;
      logic       lt_n;
      logic       le;
      logic       bi_n;
      logic [3:0] sel;
      logic [3:0] a;
   } obs_t;

   typedef struct {
      logic [15:0] bcd;
      logic        lz;
      int          tn_at;
      int          tn_len;
      logic [3:0]  mask;   // bit k = digit k lit in HOLD (without lamp test)
   } vec_t;

   localparam obs_t RESET_OBS = '{fd: 1'b0, lt_n: 1'b1, le: 1'b0, bi_n: 1'b0,
                                  sel: 4'b0000, a: 4'h0};

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   obs_t exp_q[$];
   vec_t vecs[8];

   hc4511_scan_driver_if #(.DIGITS(4)) bus ();

   hc4511_scan_driver #(
      .DIGITS   (4),
      .SCAN_DIV (8),
      .BLANK_CYC(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic obs_t sample();
      obs_t o;
      o.fd   = bus.frame_done;
      o.lt_n = bus.LT_N;
      o.le   = bus.LE;
      o.bi_n = bus.BI_N;
      o.sel  = bus.dig_sel;
      o.a    = bus.A;
      return o;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Expected outputs for one frame showing val: 3 blanked cycles then
   // 5 HOLD cycles per digit, LT_N low on samples [lt_at, lt_at+lt_len).
   task automatic push_frame(input logic [15:0] val, input logic [3:0] mask,
                             input int lt_at, input int lt_len);
      obs_t e;
      int   slot;
      for (int j = 0; j < 32; j++) begin
         slot   = j / 8;
         e.a    = val[4*slot +: 4];
         e.lt_n = !(j >= lt_at && j < lt_at + lt_len);
         e.fd   = (j == 31);
         if ((j % 8) < 3) begin
            e.le   = 1'b0;
            e.bi_n = 1'b0;
            e.sel  = 4'b0000;
         end else begin
            e.le   = 1'b1;
            e.sel  = 4'b0001 << slot;
            e.bi_n = !e.lt_n ? 1'b1 : mask[slot];
         end
         exp_q.push_back(e);
      end
   endtask

   // Observe one frame (entered right after a frame_done sample) against
   // the scoreboard, optionally loading at samples l1/l2 and pulling test_n
   // low after samples [tn_at, tn_at+tn_len).
   task automatic check_frame(input int l1, input logic [15:0] v1,
                              input int l2, input logic [15:0] v2,
                              input int tn_at, input int tn_len);
      static int frame_no = 0;
      obs_t o;
      obs_t e;
      for (int j = 0; j < 32; j++) begin
         @(negedge clk);
         o = sample();
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_underflow frame%0d j%0d actual=empty expected=entry", frame_no, j);
         end else begin
            e = exp_q.pop_front();
            check($sformatf("frame%0d_j%0d", frame_no, j), 32'(o), 32'(e));
         end
         bus.load = 1'b0;
         if (j == l1) begin
            bus.bcd_in = v1;
            bus.load   = 1'b1;
         end else if (j == l2) begin
            bus.bcd_in = v2;
            bus.load   = 1'b1;
         end
         bus.test_n = !(tn_len > 0 && j >= tn_at && j < tn_at + tn_len);
      end
      bus.load = 1'b0;
      frame_no++;
   endtask

   // Hold reset for n cycles checking outputs, release, then measure the
   // first HOLD and first frame_done; returns right after frame_done.
   task automatic do_reset(input int n);
      int   first_hold = -1;
      int   fd_at      = -1;
      obs_t o;
      rst      = 1'b1;
      bus.load = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check($sformatf("reset_out_%0d", i), 32'(sample()), 32'(RESET_OBS));
      end
      rst = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         o = sample();
         if (first_hold < 0 && o.sel != 4'b0000) begin
            first_hold = c;
            check("first_hold_obs", 32'(o),
                  32'(obs_t'{fd: 1'b0, lt_n: 1'b1, le: 1'b1, bi_n: 1'b1,
                             sel: 4'b0001, a: 4'h0}));
         end
         if (o.fd) begin
            fd_at = c;
            break;
         end
      end
      check("first_hold_cycle", 32'(first_hold), 32'd4);
      check("first_frame_done_cycle", 32'(fd_at), 32'd32);
   endtask

   initial begin
      logic [15:0] next_val;

      vecs[0] = '{bcd: 16'h1234, lz: 1'b0, tn_at: 0,  tn_len: 0,  mask: 4'b1111};
      vecs[1] = '{bcd: 16'h0105, lz: 1'b1, tn_at: 0,  tn_len: 0,  mask: 4'b0111};
      vecs[2] = '{bcd: 16'h0000, lz: 1'b1, tn_at: 0,  tn_len: 0,  mask: 4'b0001};
      vecs[3] = '{bcd: 16'h0000, lz: 1'b0, tn_at: 0,  tn_len: 0,  mask: 4'b1111};
      vecs[4] = '{bcd: 16'h0070, lz: 1'b1, tn_at: 0,  tn_len: 0,  mask: 4'b0011};
      vecs[5] = '{bcd: 16'h9A0F, lz: 1'b1, tn_at: 0,  tn_len: 0,  mask: 4'b1111};
      vecs[6] = '{bcd: 16'h0000, lz: 1'b1, tn_at: -1, tn_len: 32, mask: 4'b0001};
      vecs[7] = '{bcd: 16'h00A0, lz: 1'b1, tn_at: 0,  tn_len: 0,  mask: 4'b0011};

      bus.bcd_in = 16'h0000;
      bus.load   = 1'b0;
      bus.lz_en  = 1'b0;
      bus.test_n = 1'b1;

      // Power-on reset: 3 cycles
      do_reset(3);

      // Frame after reset shows zeros; load the first table value mid-frame
      push_frame(16'h0000, 4'b1111, 0, 0);
      check_frame(10, vecs[0].bcd, -1, 16'h0, 0, 0);

      // Table-driven frames; each frame loads the next row's value
      for (int i = 0; i < 8; i++) begin
         next_val   = (i < 7) ? vecs[i+1].bcd : 16'h1234;
         bus.lz_en  = vecs[i].lz;
         bus.test_n = (vecs[i].tn_len > 0 && vecs[i].tn_at < 0) ? 1'b0 : 1'b1;
         push_frame(vecs[i].bcd, vecs[i].mask, vecs[i].tn_at + 1, vecs[i].tn_len);
         check_frame(10, next_val, -1, 16'h0, vecs[i].tn_at, vecs[i].tn_len);
      end

      // Tear-free: 5678 loaded mid-frame must not disturb the 1234 frame
      bus.lz_en  = 1'b0;
      bus.test_n = 1'b1;
      push_frame(16'h1234, 4'b1111, 0, 0);
      check_frame(12, 16'h5678, -1, 16'h0, 0, 0);

      // 5678 frame; 1111 loaded early, then 4321 on the frame_done cycle
      push_frame(16'h5678, 4'b1111, 0, 0);
      check_frame(5, 16'h1111, 30, 16'h4321, 0, 0);

      push_frame(16'h4321, 4'b1111, 0, 0);
      check_frame(10, 16'h0000, -1, 16'h0, 0, 0);

      // Lamp test for 20 cycles over a fully suppressed zero value
      bus.lz_en = 1'b1;
      push_frame(16'h0000, 4'b0001, 9, 20);
      check_frame(10, 16'h9876, -1, 16'h0, 8, 20);

      // Mid-frame reset during the HOLD of digit 2 of 9876
      bus.lz_en  = 1'b0;
      bus.test_n = 1'b1;
      for (int j = 0; j <= 20; j++) begin
         @(negedge clk);
      end
      check("hold_idx2_before_reset", 32'(sample()),
            32'(obs_t'{fd: 1'b0, lt_n: 1'b1, le: 1'b1, bi_n: 1'b1,
                       sel: 4'b0100, a: 4'h8}));
      do_reset(3);

      // Restarted scan shows the cleared work value
      push_frame(16'h0000, 4'b1111, 0, 0);
      check_frame(-1, 16'h0, -1, 16'h0, 0, 0);

      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
